// File: rtl/vga_fb_scanout.sv
// VGA timing generator with a scaled, host-writable framebuffer and a colour-bar test mode.
// Outputs lag the h/v counters by two cycles: registered RAM read, then output register.
module vga_fb_scanout #(
  parameter int H_ACTIVE = 200,
  parameter int H_FP     = 10,
  parameter int H_SYNC   = 32,
  parameter int H_BP     = 23,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 24,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1,
  parameter int BPP      = 3,
  parameter int SCALE_X  = 1,
  parameter int SCALE_Y  = 4,
  localparam int FB_W    = H_ACTIVE / SCALE_X,
  localparam int FB_H    = V_ACTIVE / SCALE_Y,
  localparam int DEPTH   = FB_W * FB_H,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           PATTERN,
  input  logic           WR_STROBE,
  input  logic [AW-1:0]  WR_ADDR,
  input  logic [BPP-1:0] WR_DATA,
  output logic [BPP-1:0] RGB,
  output logic           HSYNC,
  output logic           VSYNC,
  output logic           DE,
  output logic           FRAME_START,
  output logic           WR_ERR
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT + 1);
  localparam int VW    = $clog2(V_TOT + 1);
  localparam int SXW   = $clog2(SCALE_X) + 1;
  localparam int SYW   = $clog2(SCALE_Y) + 1;
  localparam int ACC_W = HW + 1;

  localparam logic [HW-1:0]    H_LAST     = HW'(H_TOT - 1);
  localparam logic [HW-1:0]    H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0]    H_ACT_LAST = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0]    HS_BEG     = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]    HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0]    V_LAST     = VW'(V_TOT - 1);
  localparam logic [VW-1:0]    V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0]    VS_BEG     = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]    VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [SXW-1:0]   SX_LAST    = SXW'(SCALE_X - 1);
  localparam logic [SYW-1:0]   SY_LAST    = SYW'(SCALE_Y - 1);
  localparam logic [AW-1:0]    FB_W_A     = AW'(FB_W);
  localparam logic [AW:0]      DEPTH_A    = (AW + 1)'(DEPTH);
  localparam logic [ACC_W-1:0] H_ACT_ACC  = ACC_W'(H_ACTIVE);
  localparam logic             HS_ON      = (HS_POL != 0);
  localparam logic             VS_ON      = (VS_POL != 0);

  logic [HW-1:0]    h;
  logic [VW-1:0]    v;
  logic             h_wrap, v_wrap, active, line_end, hs_act, vs_act, first_px;
  logic [AW-1:0]    col, row_base, rd_addr;
  logic [SXW-1:0]   sub_x;
  logic [SYW-1:0]   sub_y;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [3:0]       bar;
  logic             s1, s2, s3, wr_fire, addr_ok;
  logic [BPP-1:0]   mem [0:DEPTH-1];
  logic [BPP-1:0]   rd_data, bar_q;
  logic             de_q, hs_q, vs_q, fs_q, pat_q;

  assign h_wrap   = (h == H_LAST);
  assign v_wrap   = h_wrap && (v == V_LAST);
  assign active   = (h < H_ACT) && (v < V_ACT);
  assign line_end = (h == H_ACT_LAST) && (v < V_ACT);
  assign hs_act   = (h >= HS_BEG) && (h < HS_END);
  assign vs_act   = (v >= VS_BEG) && (v < VS_END);
  assign first_px = (h == '0) && (v == '0);
  assign rd_addr  = row_base + col;
  assign acc_nxt  = acc + ACC_W'(8);

  always_ff @(posedge CLK) begin
    if (RST) begin
      h <= '0;
      v <= '0;
    end else if (h_wrap) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + VW'(1);
    end else begin
      h <= h + HW'(1);
    end
  end

  // Replication counters stand in for a multiplier: row_base steps by FB_W every SCALE_Y lines.
  always_ff @(posedge CLK) begin
    if (RST || v_wrap) begin
      col      <= '0;
      sub_x    <= '0;
      sub_y    <= '0;
      row_base <= '0;
    end else if (line_end) begin
      col   <= '0;
      sub_x <= '0;
      if (sub_y == SY_LAST) begin
        sub_y    <= '0;
        row_base <= row_base + FB_W_A;
      end else begin
        sub_y <= sub_y + SYW'(1);
      end
    end else if (active) begin
      if (sub_x == SX_LAST) begin
        sub_x <= '0;
        col   <= col + AW'(1);
      end else begin
        sub_x <= sub_x + SXW'(1);
      end
    end
  end

  // acc tracks h*8 - bar*H_ACTIVE, so bar follows (h*8)/H_ACTIVE without a divider.
  always_ff @(posedge CLK) begin
    if (RST || h_wrap) begin
      acc <= '0;
      bar <= '0;
    end else if (h < H_ACT) begin
      if (acc_nxt >= H_ACT_ACC) begin
        acc <= acc_nxt - H_ACT_ACC;
        bar <= bar + 4'd1;
      end else begin
        acc <= acc_nxt;
      end
    end
  end

  assign wr_fire = s2 && !s3;
  assign addr_ok = ({1'b0, WR_ADDR} < DEPTH_A);

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      WR_ERR <= 1'b0;
    end else begin
      s1 <= WR_STROBE;
      s2 <= s1;
      s3 <= s2;
      if (wr_fire && !addr_ok) WR_ERR <= 1'b1;
    end
  end

  // Read-before-write on a shared address: the scan sees the old pixel.
  always_ff @(posedge CLK) begin
    if (wr_fire && addr_ok) mem[WR_ADDR] <= WR_DATA;
    rd_data <= mem[rd_addr];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      de_q        <= 1'b0;
      hs_q        <= ~HS_ON;
      vs_q        <= ~VS_ON;
      fs_q        <= 1'b0;
      pat_q       <= 1'b0;
      bar_q       <= '0;
      RGB         <= '0;
      DE          <= 1'b0;
      HSYNC       <= ~HS_ON;
      VSYNC       <= ~VS_ON;
      FRAME_START <= 1'b0;
    end else begin
      de_q        <= active;
      hs_q        <= hs_act ? HS_ON : ~HS_ON;
      vs_q        <= vs_act ? VS_ON : ~VS_ON;
      fs_q        <= first_px;
      pat_q       <= PATTERN;
      bar_q       <= BPP'(bar);
      RGB         <= de_q ? (pat_q ? bar_q : rd_data) : '0;
      DE          <= de_q;
      HSYNC       <= hs_q;
      VSYNC       <= vs_q;
      FRAME_START <= fs_q;
    end
  end

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Bench for vga_fb_scanout on a small 12x4 raster (2x2 replication, 6x2 framebuffer).
// A negedge scoreboard models every output cycle; scenario tasks add targeted checks.
module tb_vga_fb_scanout;

  localparam int HA = 12, HFP = 2, HSW = 3, HBP = 2;
  localparam int VA = 4, VFP = 1, VSW = 2, VBP = 1;
  localparam int SX = 2, SY = 2;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FBW = HA / SX;
  localparam int DEPTH = FBW * (VA / SY);
  localparam logic HS_ON = 1'b0;
  localparam logic VS_ON = 1'b1;
  localparam logic [6:0] RST_EXP = {1'b0, ~HS_ON, ~VS_ON, 1'b0, 3'b000};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pattern = 1'b0;
  logic       wr_strobe = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [2:0] wr_data = '0;
  logic [2:0] rgb;
  logic       hsync, vsync, de, frame_start, wr_err;

  int vectors = 0;
  int miscompares = 0;
  logic sb_on = 1'b0;

  logic [6:0] exp_q[$];
  int         m_h = 0, m_v = 0, wr_cnt = 0;
  logic [2:0] fb [0:DEPTH-1];
  logic       m_err = 1'b0;
  logic       prev_stb = 1'b0;
  logic [3:0] pw_addr = '0;
  logic [2:0] pw_data = '0;

  vga_fb_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(0), .VS_POL(1), .BPP(3), .SCALE_X(SX), .SCALE_Y(SY)
  ) dut (
    .CLK(clk), .RST(rst), .PATTERN(pattern), .WR_STROBE(wr_strobe),
    .WR_ADDR(wr_addr), .WR_DATA(wr_data), .RGB(rgb), .HSYNC(hsync),
    .VSYNC(vsync), .DE(de), .FRAME_START(frame_start), .WR_ERR(wr_err)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] model_out();
    logic act, hs_a, vs_a, fs;
    logic [2:0] px;
    act  = (m_h < HA) && (m_v < VA);
    hs_a = (m_h >= HA + HFP) && (m_h < HA + HFP + HSW);
    vs_a = (m_v >= VA + VFP) && (m_v < VA + VFP + VSW);
    fs   = (m_h == 0) && (m_v == 0);
    px   = 3'b000;
    if (act) px = pattern ? 3'((m_h * 8) / HA) : fb[(m_v / SY) * FBW + m_h / SX];
    return {act, hs_a ? HS_ON : ~HS_ON, vs_a ? VS_ON : ~VS_ON, fs, px};
  endfunction

  // Scoreboard: push the expectation for this cycle's counter state, pop it two cycles later.
  always @(negedge clk) begin
    logic [6:0] e;
    if (rst) begin
      exp_q.delete();
      exp_q.push_back(RST_EXP);
      exp_q.push_back(RST_EXP);
      m_h = 0; m_v = 0; m_err = 1'b0; wr_cnt = 0; prev_stb = 1'b0;
    end else begin
      if (exp_q.size() == 2) begin
        e = exp_q.pop_front();
        if (sb_on) begin
          vectors++;
          if ({wr_err, de, hsync, vsync, frame_start, rgb} !== {m_err, e}) begin
            miscompares++;
            $display("FAIL scan t=%0t {err,de,hs,vs,fs,rgb} got=%b expected=%b", $time,
                     {wr_err, de, hsync, vsync, frame_start, rgb}, {m_err, e});
          end
        end
      end
      exp_q.push_back(model_out());
      if (wr_cnt > 0) begin
        wr_cnt--;
        if (wr_cnt == 0) begin
          if (int'(pw_addr) < DEPTH) fb[pw_addr] = pw_data;
          else m_err = 1'b1;
        end
      end
      if (wr_strobe && !prev_stb) begin
        wr_cnt = 2; pw_addr = wr_addr; pw_data = wr_data;
      end
      prev_stb = wr_strobe;
      m_h++;
      if (m_h == HT) begin
        m_h = 0; m_v++;
        if (m_v == VT) m_v = 0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic host_write(input logic [3:0] a, input logic [2:0] d);
    step(1); wr_addr = a; wr_data = d; wr_strobe = 1'b1;
    step(1); wr_strobe = 1'b0;
    step(1);
  endtask

  task automatic wait_fs();
    int n = 0;
    while (frame_start !== 1'b1 && n < 3 * HT * VT) begin step(1); n++; end
    vectors++;
    if (frame_start !== 1'b1) begin
      miscompares++; $display("FAIL fs_timeout got=%b required=1", frame_start);
    end
  endtask

  task automatic test_reset();
    int t, t_hs, w;
    rst = 1'b1; step(3); rst = 1'b0;
    vectors += 6;
    if (rgb !== 3'b000) begin miscompares++; $display("FAIL reset_rgb got=%b required=000", rgb); end
    if (de !== 1'b0) begin miscompares++; $display("FAIL reset_de got=%b required=0", de); end
    if (hsync !== ~HS_ON) begin miscompares++; $display("FAIL reset_hsync got=%b required=%b", hsync, ~HS_ON); end
    if (vsync !== ~VS_ON) begin miscompares++; $display("FAIL reset_vsync got=%b required=%b", vsync, ~VS_ON); end
    if (frame_start !== 1'b0) begin miscompares++; $display("FAIL reset_fs got=%b required=0", frame_start); end
    if (wr_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got=%b required=0", wr_err); end
    t = 0;
    while (hsync !== HS_ON && t < 200) begin step(1); t++; end
    vectors++;
    if (t != HA + HFP + 2) begin miscompares++; $display("FAIL hsync_first got=%0d required=%0d", t, HA + HFP + 2); end
    t_hs = t; w = 0;
    while (hsync === HS_ON && w < 50) begin step(1); t++; w++; end
    vectors++;
    if (w != HSW) begin miscompares++; $display("FAIL hsync_width got=%0d required=%0d", w, HSW); end
    while (hsync !== HS_ON && t < 400) begin step(1); t++; end
    vectors++;
    if (t - t_hs != HT) begin miscompares++; $display("FAIL line_period got=%0d required=%0d", t - t_hs, HT); end
    while (vsync !== VS_ON && t < 600) begin step(1); t++; end
    vectors++;
    if (t != (VA + VFP) * HT + 2) begin miscompares++; $display("FAIL vsync_first got=%0d required=%0d", t, (VA + VFP) * HT + 2); end
    w = 0;
    while (vsync === VS_ON && w < 400) begin step(1); w++; end
    vectors++;
    if (w != VSW * HT) begin miscompares++; $display("FAIL vsync_width got=%0d required=%0d", w, VSW * HT); end
  endtask

  task automatic test_fb_scale();
    logic [2:0] img [0:DEPTH-1];
    for (int k = 0; k < DEPTH; k++) img[k] = 3'(k);
    img[0] = 3'b001; img[FBW-1] = 3'b100; img[FBW] = 3'b010;
    host_write(4'(0), 3'b001);
    host_write(4'(FBW - 1), 3'b100);
    host_write(4'(FBW), 3'b010);
    step(4);
    wait_fs();
    for (int i = 0; i < HA; i++) begin
      vectors++;
      if (rgb !== img[i / SX] || de !== 1'b1) begin
        miscompares++; $display("FAIL line0_px%0d got=%0d/de%b required=%0d/de1", i, rgb, de, img[i / SX]);
      end
      step(1);
    end
    vectors++;
    if (de !== 1'b0 || rgb !== 3'b000) begin miscompares++; $display("FAIL line0_end got=de%b/%0d required=de0/0", de, rgb); end
    step(SY * HT - HA);
    for (int i = 0; i < HA; i++) begin
      vectors++;
      if (rgb !== img[FBW + i / SX]) begin
        miscompares++; $display("FAIL line2_px%0d got=%0d required=%0d", i, rgb, img[FBW + i / SX]);
      end
      step(1);
    end
  endtask

  task automatic test_pattern();
    pattern = 1'b1; step(3);
    wait_fs();
    for (int i = 0; i < HA; i++) begin
      vectors++;
      if (rgb !== 3'((i * 8) / HA)) begin
        miscompares++; $display("FAIL bar_px%0d got=%0d required=%0d", i, rgb, (i * 8) / HA);
      end
      step(1);
    end
    step(HT + 3); pattern = 1'b0;
    step(2); pattern = 1'b1;
    step(1); pattern = 1'b0;
    step(HT * VT);
  endtask

  task automatic test_write_err();
    host_write(4'(DEPTH - 1), 3'b110);
    step(2);
    vectors++;
    if (wr_err !== 1'b0) begin miscompares++; $display("FAIL err_last_valid got=%b required=0", wr_err); end
    host_write(4'(DEPTH), 3'b101);
    step(2);
    vectors++;
    if (wr_err !== 1'b1) begin miscompares++; $display("FAIL err_set got=%b required=1", wr_err); end
    host_write(4'd15, 3'b111);
    step(2 * HT * VT);
    vectors++;
    if (wr_err !== 1'b1) begin miscompares++; $display("FAIL err_sticky got=%b required=1", wr_err); end
  endtask

  task automatic test_midline_reset();
    int n = 0;
    wait_fs();
    step(2 * HT + 6);
    rst = 1'b1; step(1); rst = 1'b0;
    vectors += 3;
    if (de !== 1'b0 || rgb !== 3'b000) begin miscompares++; $display("FAIL mid_rst_video got=de%b/%0d required=de0/0", de, rgb); end
    if (hsync !== ~HS_ON || vsync !== ~VS_ON) begin miscompares++; $display("FAIL mid_rst_sync got=%b%b required=%b%b", hsync, vsync, ~HS_ON, ~VS_ON); end
    if (wr_err !== 1'b0) begin miscompares++; $display("FAIL mid_rst_err got=%b required=0", wr_err); end
    while (frame_start !== 1'b1 && n < 20) begin step(1); n++; end
    vectors++;
    if (n != 2) begin miscompares++; $display("FAIL mid_rst_restart got=%0d required=2", n); end
    step(HT * VT);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < DEPTH; k++) host_write(4'(k), 3'((k * 5 + 3) % 8));
    step(4);
    wait_fs();
    for (int i = 0; i < HA; i++) begin
      vectors++;
      if (rgb !== 3'(((i / SX) * 5 + 3) % 8)) begin
        miscompares++; $display("FAIL b2b_px%0d got=%0d required=%0d", i, rgb, ((i / SX) * 5 + 3) % 8);
      end
      step(1);
    end
    step(HT * VT);
  endtask

  initial begin
    step(3);
    rst = 1'b0;
    for (int k = 0; k < DEPTH; k++) host_write(4'(k), 3'(k));
    step(4);
    sb_on = 1'b1;
    test_reset();
    test_fb_scale();
    test_pattern();
    test_write_err();
    test_midline_reset();
    test_back_to_back();
    step(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vga_fb_scanout.md
Name: vga_fb_scanout

Overview:
- Parametrised VGA timing generator with an integrated scaled framebuffer.
- Host writes pixels through an asynchronous strobe port; the block scans the framebuffer out as RGB with HSYNC/VSYNC/DE.
- Successor to the fixed 200x600 single-pixel-colour generator. Adds configurable timing, sync polarity, pixel depth, X/Y pixel replication, a test-pattern mode and a synchronised write path.
- Sits between the PLL pixel clock and the GPIO pins.

Parameters:
- H_ACTIVE, 200, visible pixels per line
- H_FP, 10, horizontal front porch (cycles)
- H_SYNC, 32, horizontal sync width
- H_BP, 23, horizontal back porch
- V_ACTIVE, 600, visible lines
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vertical sync width
- V_BP, 24, vertical back porch
- HS_POL, 1, HSYNC asserted level
- VS_POL, 1, VSYNC asserted level
- BPP, 3, bits per pixel, {R,G,B} split by caller
- SCALE_X, 1, horizontal replication; H_ACTIVE divisible by it
- SCALE_Y, 4, vertical replication; V_ACTIVE divisible by it
- Derived: FB_W=H_ACTIVE/SCALE_X, FB_H=V_ACTIVE/SCALE_Y, DEPTH=FB_W*FB_H, AW=clog2(DEPTH)

Ports:
- CLK  in  1  pixel clock
- RST  in  1  synchronous reset, active high
- PATTERN  in  1  1 = colour-bar test pattern instead of framebuffer
- WR_STROBE  in  1  asynchronous host write strobe; a rising edge means write
- WR_ADDR  in  AW  host write address, linear row-major
- WR_DATA  in  BPP  host write pixel
- RGB  out  BPP  pixel output
- HSYNC  out  1  horizontal sync
- VSYNC  out  1  vertical sync
- DE  out  1  active-video flag, aligned with RGB
- FRAME_START  out  1  one-cycle pulse, aligned with first active pixel of the frame
- WR_ERR  out  1  sticky: a write hit an address >= DEPTH

Behaviour:
- Reset:
  - Single clock CLK; RST is synchronous, active high.
  - On reset: h/v counters=0; RGB=0, DE=0, FRAME_START=0, WR_ERR=0; HSYNC=!HS_POL, VSYNC=!VS_POL; pipeline and synchroniser cleared.
  - Framebuffer contents are not cleared.
  - Reset asserted mid-line restarts at h=0,v=0 on the cycle after release.
- Counters:
  - h runs 0..H_TOT-1, with H_TOT=H_ACTIVE+H_FP+H_SYNC+H_BP.
  - On h wrap, v increments over 0..V_TOT-1 and wraps to 0.
  - Defaults give 265x629.
- Timing regions:
  - Active when h<H_ACTIVE and v<V_ACTIVE.
  - HSYNC asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, on every line including vertical blank.
  - VSYNC asserted for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, for whole lines.
- Address generation (no multiplier):
  - col_ctr and sub_x advance each active pixel; col increments when sub_x wraps at SCALE_X.
  - row_base += FB_W when sub_y wraps at SCALE_Y at end of each active line.
  - All reset to 0 at v wrap; read address = row_base + col.
- Pipeline:
  - Fixed 2-cycle latency from counter state to outputs. Stage 1: registered RAM read. Stage 2: output register.
  - HSYNC, VSYNC, DE and FRAME_START are delayed identically, so all outputs stay mutually aligned.
  - RGB is forced to 0 whenever the delayed DE=0.
- PATTERN mode:
  - RGB = bar index, where bar = (h*8)/H_ACTIVE truncated to BPP bits, computed via a threshold counter.
  - Same latency as framebuffer mode. Switching takes effect at the next pixel, with no glitch on syncs.
- Write path:
  - WR_STROBE passes a 2-flop synchroniser, then rising-edge detection.
  - On the detect cycle, WR_ADDR/WR_DATA are sampled directly. Host holds them stable from before the strobe rise until 3 CLK after.
  - Address < DEPTH: RAM write. Otherwise: no write and WR_ERR=1 until RST.
  - Strobe edges closer than 3 CLK apart may be merged; max write rate is 1 per 3 CLK.
- RAM:
  - Simple dual-port inferred block RAM: one read port, one write port.
  - Write and read may proceed in the same cycle, including during active video.
  - Same-address collision: read returns old data.

Test Plan:
- RST 3 cycles, release, defaults -> first HSYNC rise 212 cycles after release (210+2 latency), width 32; line period 265; VSYNC high for lines 601..604 (4x265 cycles); frame 166685 cycles.
- Write addr 0=3'b001, addr 199=3'b100, addr 200=3'b010 -> line 0 pixel 0 RGB=1 and pixel 199 RGB=4; lines 0-3 identical; line 4 pixel 0 RGB=2; FRAME_START aligns with first RGB=1.
- SCALE_X=2, SCALE_Y=2, H_ACTIVE=8, V_ACTIVE=4, small porches; fill addr k=k -> line 0 outputs 0,0,1,1,2,2,3,3; line 2 outputs 4,4,5,5,...
- WR_ADDR=30000 strobe -> no RAM change, WR_ERR=1; persists over 2 frames; cleared only by RST.
- PATTERN=1 -> 8 bars of 25 pixels, values 0..7; DE/sync timing identical to PATTERN=0.
- RST asserted at h=100,v=300 for 1 cycle -> outputs at reset values next cycle; timing restarts at h=0,v=0; RAM contents preserved.
